// File: rtl/lbp_pkg.sv
// Shared LBP definitions: code constants, the even-code table and decoded-entry layout.
// Used by both the encoder and the decoder so the two sides never disagree on the code map.
package lbp_pkg;

    localparam int CODE_W  = 4;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = DATA_W + 2;

    localparam logic [0:CODE_W-1] CODE_NONE = 4'b0001;

    // EVEN_CODE[i] is the code that sets m_data bit i (bit 0 = MSB, highest priority).
    localparam logic [0:CODE_W-1] EVEN_CODE [DATA_W] = '{
        4'b1110, 4'b1100, 4'b1010, 4'b1000,
        4'b0110, 4'b0100, 4'b0010, 4'b0000
    };

    typedef struct packed {
        logic [0:DATA_W-1] data;
        logic              none;
        logic              err;
    } entry_t;

endpackage

// File: rtl/lbp_code_dec.sv
// Pure combinational mapping from one LBP code word to a decoded entry.
module lbp_code_dec
    import lbp_pkg::*;
(
    input  logic [0:CODE_W-1] code,
    output logic [0:DATA_W-1] data,
    output logic              none,
    output logic              err
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data = '0;
        none = 1'b0;
        err  = 1'b0;
        if (code == CODE_NONE) begin
            none = 1'b1;
        end else if (code[CODE_W-1]) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (code == EVEN_CODE[i]) data[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lbp_decoder.sv
// LBP code decoder: decodes accepted codes into a 2-entry output FIFO and keeps
// saturating counts of illegal and no-bit-set codes plus a sticky error flag.
module lbp_decoder
    import lbp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:3]        s_code,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [0:7]        m_data,
    output logic              m_none,
    output logic              m_err,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  none_cnt,
    output logic              err_sticky
);

    entry_t            dec_entry;
    logic [0:DATA_W-1] dec_data;
    logic              dec_none;
    logic              dec_err;
    entry_t            mem [2];
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              accept;
    logic              pop;

    lbp_code_dec u_code_dec (
        .code (s_code),
        .data (dec_data),
        .none (dec_none),
        .err  (dec_err)
    );

    assign dec_entry  = '{data: dec_data, none: dec_none, err: dec_err};
    assign accept     = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign count_next = count + 2'(accept) - 2'(pop);

    assign m_valid = (count != 2'd0);
    assign m_data  = m_valid ? mem[0].data : '0;
    assign m_none  = m_valid && mem[0].none;
    assign m_err   = m_valid && mem[0].err;

    // s_ready is registered from the next occupancy, so it never depends on m_ready
    // combinationally and stays low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            s_ready <= 1'b0;
            // NOTE: the two storage slots are reset too; it is cheap here and keeps
            // simulation free of X even though outputs are masked by m_valid.
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            count   <= count_next;
            s_ready <= (count_next != 2'd2);
            if (pop) begin
                mem[0] <= accept ? dec_entry : mem[1];
            end else if (accept && count == 2'd0) begin
                mem[0] <= dec_entry;
            end
            if (accept && !pop && count == 2'd1) begin
                mem[1] <= dec_entry;
            end
        end
    end

    // Counters follow accepts, not pops; clr wins but still counts a coincident accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            none_cnt   <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_cnt    <= CNT_W'(accept && dec_err);
            none_cnt   <= CNT_W'(accept && dec_none);
            err_sticky <= accept && dec_err;
        end else begin
            if (accept && dec_err) begin
                err_sticky <= 1'b1;
                if (!(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
            end
            if (accept && dec_none && !(&none_cnt)) begin
                none_cnt <= none_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/lbp_decoder.md
LBP_DECODER -- requirements
Module: lbp_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the error and none counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_code  input  [0:3]  LBP code word; bit 0 is the MSB.
REQ-005 SHALL have port s_valid  input  1  s_code valid.
REQ-006 SHALL have port s_ready  output  1  decoder can accept s_code.
REQ-007 SHALL have port m_data  output  [0:7]  reconstructed pattern; bit 0 is the MSB and highest priority.
REQ-008 SHALL have port m_none  output  1  head entry came from the no-bit-set code 0001.
REQ-009 SHALL have port m_err  output  1  head entry came from an illegal code.
REQ-010 SHALL have port m_valid  output  1  m_data/m_none/m_err valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port clr  input  1  synchronous clear of counters and sticky flag.
REQ-013 SHALL have port err_cnt  output  [CNT_W-1:0]  number of accepted illegal codes, saturating.
REQ-014 SHALL have port none_cnt  output  [CNT_W-1:0]  number of accepted 0001 codes, saturating.
REQ-015 SHALL have port err_sticky  output  1  set by any accepted illegal code, cleared only by clr or reset.

Function
REQ-016 SHALL treat the transfer s_valid&&s_ready as an accept and m_valid&&m_ready as a pop.
REQ-017 SHALL decode an even code c=2k (k=0..7) to a one-hot m_data with only bit (7-k) set, giving 1110->bit0, 1100->bit1, and so on down to 0000->bit7, with m_none=0 and m_err=0.
REQ-018 SHALL decode 0001 to m_data=8'h00, m_none=1 and m_err=0.
REQ-019 SHALL decode any other odd code (0011,0101,0111,1001,1011,1101,1111) to m_data=8'h00, m_none=0 and m_err=1.
REQ-020 SHALL buffer decoded entries in a 2-entry FIFO, in order, with each entry holding {data, none, err}.
REQ-021 SHALL drive s_ready=1 exactly when the FIFO holds fewer than 2 entries, with no combinational path from m_ready to s_ready.
REQ-022 SHALL present an entry accepted in cycle N on m_valid in cycle N+1 at the earliest (latency 1); empty-FIFO bypass is forbidden.
REQ-023 SHALL, on a simultaneous accept and pop with occupancy 1, keep occupancy at 1 and present the new entry next cycle.
REQ-024 SHALL hold m_data/m_none/m_err/m_valid stable while m_valid=1 and m_ready=0.
REQ-025 SHALL drive m_data=0, m_none=0 and m_err=0 whenever m_valid=0.
REQ-026 SHALL increment err_cnt and none_cnt on accept (not on pop), saturating at all-ones without wrapping.
REQ-027 SHALL, when clr coincides with a counted accept, set that counter to 1 and set err_sticky to the accepted entry's err value; FIFO contents are unaffected by clr.
REQ-028 SHALL ignore s_code when s_valid=0 or s_ready=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately force FIFO empty, m_valid=0, m_data=0, m_none=0, m_err=0, s_ready=0, err_cnt=0, none_cnt=0 and err_sticky=0.
REQ-030 SHALL assert s_ready=1 in the first clock after rst_n deasserts.
REQ-031 SHALL, on reset asserted mid-transfer, discard all buffered entries, none of which reappear after reset.

Structure
REQ-032 SHALL place the code constants (CODE_NONE=4'b0001 and the even-code table) and the entry field widths in a shared LBP package also used by the encoder.
REQ-033 SHALL implement the pure code-to-entry mapping as a combinational sub-module named lbp_code_dec, with FIFO, handshake and counters in lbp_decoder.

Verification
REQ-034 SHALL verify: accept 1110 then 0000 with m_ready=1 -> m_data 8'h80 then 8'h01, each one cycle after its accept, with m_none=0 and m_err=0.
REQ-035 SHALL verify: accept 0001 -> m_data=8'h00, m_none=1, none_cnt=1 and err_sticky=0.
REQ-036 SHALL verify: accept 1011 -> m_data=8'h00, m_err=1, err_cnt=1 and err_sticky=1; a later clr -> err_cnt=0 and err_sticky=0.
REQ-037 SHALL verify: m_ready=0 and three back-to-back codes 1100, 1010, 1000 -> s_ready drops after 2 accepts; on releasing m_ready, outputs 8'h40 then 8'h20 and the third code is accepted afterward.
REQ-038 SHALL verify: CNT_W=2 with five accepts of 0111 -> err_cnt sticks at 3.
REQ-039 SHALL verify: rst_n pulsed low with 2 entries buffered -> m_valid=0 immediately and no stale entry emerges after release.
